// File: rtl/sized_fifo_drain_arbiter_if.sv
// Handshake bundle between per-channel SizedFIFOs,
// the drain arbiter and its downstream consumer.
interface sized_fifo_drain_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int SRCW  = 2
);
  logic [NREQ-1:0]       in_empty_n;
  logic [NREQ*WIDTH-1:0] in_data;
  logic [NREQ-1:0]       in_deq;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SRCW-1:0]       out_src;
  logic                  out_busy;

  modport slave (
    input  in_empty_n, in_data, out_ready,
    output in_deq, out_valid, out_data,
    output out_src, out_busy
  );

  modport master (
    output in_empty_n, in_data, out_ready,
    input  in_deq, out_valid, out_data,
    input  out_src, out_busy
  );
endinterface

// File: rtl/sized_fifo_drain_arbiter.sv
// Burst-limited round-robin drain of NREQ FIFOs
// onto one registered valid/ready stream.
module sized_fifo_drain_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int SRCW  = 2,
  parameter int BURST = 4,
  parameter int CNTW  = 3
) (
  input logic CLK,
  input logic RST,
  input logic CLR,
  sized_fifo_drain_arbiter_if.slave bus
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state, state_n;
  logic [SRCW-1:0]  owner, owner_n;
  logic [CNTW-1:0]  cnt, cnt_n;
  logic [SRCW-1:0]  sel, rr_sel, idx;
  logic             rr_found;
  logic             can_load, any_req;
  logic             load, cont;
  logic [WIDTH-1:0] sel_data;

  assign can_load = !bus.out_valid
                 || bus.out_ready;
  assign any_req  = |bus.in_empty_n;
  assign load     = can_load && any_req
                 && !CLR && !RST;
  assign cont     = (state == LOCK)
                 && bus.in_empty_n[owner]
                 && (cnt < CNTW'(BURST));
  assign sel      = cont ? owner : rr_sel;
  assign bus.out_busy = (state == LOCK);

  // Round-robin scan starting after owner; owner itself is checked last.
  always_comb begin
    rr_sel   = owner;
    rr_found = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (int'(owner) + k >= NREQ)
        idx = SRCW'(int'(owner) + k - NREQ);
      else
        idx = SRCW'(int'(owner) + k);
      if (!rr_found && bus.in_empty_n[idx]) begin
        rr_sel   = idx;
        rr_found = 1'b1;
      end
    end
  end

  // Data mux and one-hot DEQ for the selected queue.
  always_comb begin
    sel_data   = '0;
    bus.in_deq = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == SRCW'(i)) begin
        sel_data      = bus.in_data[i*WIDTH +: WIDTH];
        bus.in_deq[i] = load;
      end
    end
  end

  // Arbitration next state: flush, grant, or drop lock when all empty.
  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n   = cnt;
    unique case (1'b1)
      CLR: begin
        state_n = IDLE;
        owner_n = SRCW'(NREQ - 1);
        cnt_n   = '0;
      end
      load: begin
        if (cont) begin
          cnt_n = cnt + CNTW'(1);
        end else begin
          owner_n = sel;
          cnt_n   = CNTW'(1);
          state_n = LOCK;
        end
      end
      (!CLR && can_load && !any_req): begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: ;
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      owner <= SRCW'(NREQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      cnt   <= cnt_n;
    end
  end

  // Output register: load, drain on accept, or hold under backpressure.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
    end else if (CLR) begin
      bus.out_valid <= 1'b0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= sel_data;
      bus.out_src   <= sel;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sized_fifo_drain_arbiter.sv
// Scoreboard bench for sized_fifo_drain_arbiter:
// FIFO models feed the DUT, a monitor checks every accepted word.
module tb_sized_fifo_drain_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int SRCW  = 2;

  typedef struct packed {
    logic [SRCW-1:0]  src;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic CLR = 1'b0;

  sized_fifo_drain_arbiter_if #(
    .NREQ(NREQ), .WIDTH(WIDTH), .SRCW(SRCW)
  ) bus ();

  sized_fifo_drain_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .SRCW(SRCW),
    .BURST(4), .CNTW(3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .CLR(CLR),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int seq      = 0;

  logic [WIDTH-1:0] fq[NREQ][$];
  logic [WIDTH-1:0] sq[NREQ][$];
  exp_t             exp_q[$];
  int               xfer_cyc[$];
  logic [NREQ-1:0]  deq_snap = '0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, expv, cyc);
    end
  endtask

  task automatic push_words(input int q, input int n);
    logic [WIDTH-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = (WIDTH'(q + 1) << 28) | WIDTH'(seq);
      seq++;
      fq[q].push_back(w);
      sq[q].push_back(w);
    end
  endtask

  task automatic expect_src(input int q, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.src  = SRCW'(q);
      e.data = sq[q].pop_front();
      exp_q.push_back(e);
    end
  endtask

  function automatic bit any_fq();
    bit r;
    r = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (fq[i].size() != 0) r = 1'b1;
    return r;
  endfunction

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || any_fq()) && t < budget) begin
      @(negedge CLK);
      t++;
    end
    chk("drain_in_time", 64'(t < budget), 64'd1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_contig(input int n);
    chk("xfer_count", 64'(xfer_cyc.size()), 64'(n));
    if (xfer_cyc.size() > 0)
      chk("no_bubble",
          64'(xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[0]),
          64'(n - 1));
  endtask

  task automatic pulse_clr();
    @(posedge CLK); #1 CLR = 1'b1;
    @(posedge CLK); #1 CLR = 1'b0;
    xfer_cyc.delete();
  endtask

  task automatic flush_mid_burst(input bit use_rst);
    exp_t e;
    int   t;
    int   n_rem;
    pulse_clr();
    @(posedge CLK); #1;
    push_words(1, 8);
    expect_src(1, 8);
    t = 0;
    while (xfer_cyc.size() < 2 && t < 30) begin
      @(negedge CLK);
      t++;
    end
    chk("flush_started", 64'(xfer_cyc.size() >= 2), 64'd1);
    chk("flush_busy_pre", 64'(bus.out_busy), 64'd1);
    @(posedge CLK); #1;
    if (use_rst) RST = 1'b1;
    else         CLR = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge CLK);
    chk("flush_deq_0", 64'(bus.in_deq), 64'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_busy",  64'(bus.out_busy),  64'd0);
    chk("flush_deq_1", 64'(bus.in_deq),    64'd0);
    if (use_rst) begin
      chk("rst_data", 64'(bus.out_data), 64'd0);
      chk("rst_src",  64'(bus.out_src),  64'd0);
    end
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) sq[i].delete();
    push_words(0, 1);
    expect_src(0, 1);
    n_rem = fq[1].size();
    for (int k = 0; k < n_rem; k++) begin
      e.src  = SRCW'(1);
      e.data = fq[1][k];
      exp_q.push_back(e);
    end
    xfer_cyc.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    CLR = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain(60);
    check_contig(1 + n_rem);
  endtask

  // FIFO models: pop on observed DEQ, then refresh DUT inputs.
  initial begin
    bus.in_empty_n = '0;
    bus.in_data    = '0;
    forever begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (deq_snap[i] && fq[i].size() != 0)
          void'(fq[i].pop_front());
      #1;
      for (int i = 0; i < NREQ; i++) begin
        bus.in_empty_n[i] = (fq[i].size() != 0);
        bus.in_data[i*WIDTH +: WIDTH] =
          (fq[i].size() != 0) ? fq[i][0] : '0;
      end
    end
  end

  // Monitor: DEQ legality each cycle and scoreboard pop on accept.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      cyc++;
      deq_snap = bus.in_deq;
      chk("deq_legal",
          64'(((bus.in_deq & ~bus.in_empty_n) == '0)
              && ($countones(bus.in_deq) <= 1)),
          64'd1);
      if (bus.out_valid && bus.out_ready) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_src",  64'(bus.out_src),  64'(e.src));
          chk("out_data", 64'(bus.out_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] w0;
    int t;
    bus.out_ready = 1'b1;

    // reset state, then single queue 2
    repeat (2) @(posedge CLK);
    #1;
    push_words(2, 5);
    expect_src(2, 5);
    @(negedge CLK);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data",  64'(bus.out_data),  64'd0);
    chk("rst_src",   64'(bus.out_src),   64'd0);
    chk("rst_busy",  64'(bus.out_busy),  64'd0);
    chk("rst_deq",   64'(bus.in_deq),    64'd0);
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    chk("t1_deq", 64'(bus.in_deq), 64'b0100);
    @(negedge CLK);
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_src",   64'(bus.out_src),   64'd2);
    wait_drain(50);
    check_contig(5);

    // all four queues busy: bursts of 4 in RR order
    pulse_clr();
    @(posedge CLK); #1;
    for (int q = 0; q < NREQ; q++) push_words(q, 8);
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < NREQ; q++) expect_src(q, 4);
    wait_drain(100);
    check_contig(32);

    // sole queue 1 keeps winning past the burst limit
    pulse_clr();
    @(posedge CLK); #1;
    push_words(1, 10);
    expect_src(1, 10);
    wait_drain(60);
    check_contig(10);

    // backpressure hold, then no-bubble release
    pulse_clr();
    @(posedge CLK); #1;
    bus.out_ready = 1'b0;
    push_words(2, 3);
    w0 = sq[2][0];
    expect_src(2, 3);
    t = 0;
    @(negedge CLK);
    while (!bus.out_valid && t < 20) begin
      @(negedge CLK);
      t++;
    end
    chk("t4_valid", 64'(bus.out_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_deq",  64'(bus.in_deq),   64'd0);
      chk("t4_hold_data", 64'(bus.out_data), 64'(w0));
      chk("t4_hold_src",  64'(bus.out_src),  64'd2);
      @(negedge CLK);
    end
    @(posedge CLK); #1 bus.out_ready = 1'b1;
    wait_drain(40);
    check_contig(3);

    // owner empties mid-burst; refilled queue 0 waits behind 3
    pulse_clr();
    @(posedge CLK); #1;
    push_words(0, 2);
    push_words(1, 2);
    push_words(3, 2);
    expect_src(0, 2);
    expect_src(1, 2);
    expect_src(3, 2);
    t = 0;
    while (fq[0].size() != 0 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    chk("t5_q0_empty", 64'(fq[0].size()), 64'd0);
    push_words(0, 2);
    expect_src(0, 2);
    wait_drain(60);
    check_contig(8);

    // flush mid-burst with CLR, then with RST
    flush_mid_burst(1'b0);
    flush_mid_burst(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
